// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: sequences one PLL reconfiguration as a burst of register
// writes (mode, N, M, C[, K], start) into the PLL config FIFO, then waits a
// fixed settle time for relock before pulsing done.
// Optional feature macro: PLL_FRAC_EN adds the fractional-N K write (addr 7).
module pll_reconfig_seq #(
  parameter int SETTLE_CYCLES = 4096,
  parameter int C_SEL         = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [31:0] cfg_k,
  output logic [5:0]  pll_addr,
  output logic [31:0] pll_value,
  output logic        pll_write,
  input  logic        pll_busy,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One captured request; K only exists when the fractional write is built in.
  typedef struct packed {
`ifdef PLL_FRAC_EN
    logic [31:0] k;
`endif
    logic [17:0] n;
    logic [17:0] m;
    logic [17:0] c0;
  } cfg_t;

`ifdef PLL_FRAC_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]    C_SEL_BITS  = 5'(C_SEL);

  state_t        state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic [CW-1:0] settle_reg, settle_next;
  cfg_t          shadow_reg, shadow_next;
  cfg_t          pend_reg, pend_next;
  logic          pending_reg, pending_next;
  cfg_t          cfg_in;

  // Pack the live request inputs into the shadow format.
  always_comb begin
    cfg_in.n  = cfg_n;
    cfg_in.m  = cfg_m;
    cfg_in.c0 = cfg_c0;
`ifdef PLL_FRAC_EN
    cfg_in.k  = cfg_k;
`endif
  end

`ifndef PLL_FRAC_EN
  // Integer-N build: K has no destination.
  logic unused_k;
  assign unused_k = ^cfg_k;
`endif

  // State, table index, settle counter and both shadow copies.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= 3'd0;
      settle_reg  <= '0;
      shadow_reg  <= '0;
      pend_reg    <= '0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      settle_reg  <= settle_next;
      shadow_reg  <= shadow_next;
      pend_reg    <= pend_next;
      pending_reg <= pending_next;
    end
  end

  // Next-state logic, write strobe and status outputs.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    settle_next  = settle_reg;
    shadow_next  = shadow_reg;
    pend_next    = pend_reg;
    pending_next = pending_reg;
    pll_write    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        // A fresh req is newer than anything left pending, so it wins.
        if (req) begin
          shadow_next  = cfg_in;
          pending_next = 1'b0;
          idx_next     = 3'd0;
          state_next   = WRITE;
        end else if (pending_reg) begin
          shadow_next  = pend_reg;
          pending_next = 1'b0;
          idx_next     = 3'd0;
          state_next   = WRITE;
        end
      end
      WRITE: begin
        busy      = 1'b1;
        pll_write = ~pll_busy;
        // idx only moves on a cycle that actually wrote, so a FIFO stall
        // neither drops nor repeats an entry.
        if (!pll_busy) begin
          if (idx_reg == LAST_IDX) begin
            settle_next = '0;
            state_next  = SETTLE;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_reg == SETTLE_LAST) begin
          state_next = DONE;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Requests that arrive while a burst is in flight (including DONE) are
    // parked; only the most recent one survives.
    if (req && (state_reg != IDLE)) begin
      pend_next    = cfg_in;
      pending_next = 1'b1;
    end
  end

  // Write table: address/data for the current entry, zero outside WRITE.
  always_comb begin
    pll_addr  = 6'd0;
    pll_value = 32'd0;
    if (state_reg == WRITE) begin
      case (idx_reg)
        3'd0: begin
          pll_addr  = 6'd0;
          pll_value = 32'h0;
        end
        3'd1: begin
          pll_addr  = 6'd3;
          pll_value = {14'b0, shadow_reg.n};
        end
        3'd2: begin
          pll_addr  = 6'd4;
          pll_value = {14'b0, shadow_reg.m};
        end
        3'd3: begin
          pll_addr  = 6'd5;
          pll_value = {9'b0, C_SEL_BITS, shadow_reg.c0};
        end
`ifdef PLL_FRAC_EN
        3'd4: begin
          pll_addr  = 6'd7;
          pll_value = shadow_reg.k;
        end
        3'd5: begin
          pll_addr  = 6'd2;
          pll_value = 32'h1;
        end
`else
        3'd4: begin
          pll_addr  = 6'd2;
          pll_value = 32'h1;
        end
`endif
        default: begin
          pll_addr  = 6'd0;
          pll_value = 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: directed bench for pll_reconfig_seq (SETTLE_CYCLES=16).
// Builds with or without PLL_FRAC_EN; expectations follow the build.
module tb_pll_reconfig_seq;
  localparam int SETTLE = 16;
`ifdef PLL_FRAC_EN
  localparam int CSEL = 2;
  localparam int NW   = 6;
`else
  localparam int CSEL = 0;
  localparam int NW   = 5;
`endif
  localparam int LOGN = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [17:0] cfg_n = '0;
  logic [17:0] cfg_m = '0;
  logic [17:0] cfg_c0 = '0;
  logic [31:0] cfg_k = '0;
  logic [5:0]  pll_addr;
  logic [31:0] pll_value;
  logic        pll_write;
  logic        pll_busy = 1'b0;
  logic        busy;
  logic        done;

  pll_reconfig_seq #(.SETTLE_CYCLES(SETTLE), .C_SEL(CSEL)) dut (
    .clk(clk), .reset(reset), .req(req),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0), .cfg_k(cfg_k),
    .pll_addr(pll_addr), .pll_value(pll_value), .pll_write(pll_write),
    .pll_busy(pll_busy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic       write_log [0:LOGN-1];
  logic [5:0] addr_log  [0:LOGN-1];
  logic       busy_log  [0:LOGN-1];
  logic       done_log  [0:LOGN-1];

  int          wr_cyc[$];
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_val[$];
  int          done_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, log, then advance to just after the next rising edge.
  task automatic run_cycle();
    #3;
    if (cyc < LOGN) begin
      write_log[cyc] = pll_write;
      addr_log[cyc]  = pll_addr;
      busy_log[cyc]  = busy;
      done_log[cyc]  = done;
    end
    if (pll_write === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(pll_addr);
      wr_val.push_back(pll_value);
      $display("[TB] cyc %0d write addr=%0d value=%h", cyc, pll_addr, pll_value);
    end
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      $display("[TB] cyc %0d done", cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_req(input logic [17:0] n, input logic [17:0] m,
                        input logic [17:0] c, input logic [31:0] k);
    req = 1'b1; cfg_n = n; cfg_m = m; cfg_c0 = c; cfg_k = k;
    run_cycle();
    req = 1'b0;
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_val.delete(); done_cyc.delete();
  endtask

  task automatic wait_done(input int target, input int bound);
    int i;
    i = 0;
    while (done_cyc.size() < target && i < bound) begin
      run_cycle();
      i++;
    end
  endtask

  // Expected table entry i for a given request.
  task automatic exp_write(input int i, input logic [17:0] n, input logic [17:0] m,
                           input logic [17:0] c, input logic [31:0] k,
                           output logic [5:0] a, output logic [31:0] v);
    logic [4:0] cs;
    cs = 5'(CSEL);
    a = 6'd2; v = 32'h1;
    case (i)
      0: begin a = 6'd0; v = 32'h0; end
      1: begin a = 6'd3; v = {14'b0, n}; end
      2: begin a = 6'd4; v = {14'b0, m}; end
      3: begin a = 6'd5; v = {9'b0, cs, c}; end
      default: begin
        if (NW == 6 && i == 4) begin a = 6'd7; v = k; end
      end
    endcase
  endtask

  task automatic check_burst(input string tag, input int base, input logic [17:0] n,
                             input logic [17:0] m, input logic [17:0] c, input logic [31:0] k);
    logic [5:0]  ea, oa;
    logic [31:0] ev, ov;
    for (int i = 0; i < NW; i++) begin
      exp_write(i, n, m, c, k, ea, ev);
      oa = (base + i < wr_addr.size()) ? wr_addr[base + i] : 6'bx;
      ov = (base + i < wr_val.size()) ? wr_val[base + i] : 32'bx;
      check($sformatf("%s_addr%0d", tag, i), 32'(oa), 32'(ea));
      check($sformatf("%s_val%0d", tag, i), ov, ev);
    end
  endtask

  function automatic int wcyc(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
  endfunction

  function automatic int dcyc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -1;
  endfunction

  initial begin
    int t0;
    int late;
    logic [31:0] v;

    // Reset state
    @(posedge clk); #1;
    idle(2);
    check("rst_write", 32'(pll_write), 32'd0);
    check("rst_addr", 32'(pll_addr), 32'd0);
    check("rst_value", pll_value, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    idle(2);

    // 1: single burst, no stalls
    clear_logs();
    t0 = cyc;
    do_req(18'h00101, 18'h01E1E, 18'h00303, 32'h8000_0000);
    wait_done(1, 80);
    idle(2);
    check("t1_nwrites", 32'(wr_cyc.size()), 32'(NW));
    check_burst("t1", 0, 18'h00101, 18'h01E1E, 18'h00303, 32'h8000_0000);
    for (int i = 0; i < NW; i++)
      check($sformatf("t1_wcyc%0d", i), 32'(wcyc(i) - t0), 32'(i + 1));
    check("t1_ndone", 32'(done_cyc.size()), 32'd1);
    check("t1_done_cyc", 32'(dcyc(0) - t0), 32'(NW + SETTLE + 1));
    check("t1_busy_c0", 32'(busy_log[t0]), 32'd0);
    check("t1_busy_c1", 32'(busy_log[t0 + 1]), 32'd1);
    check("t1_busy_last", 32'(busy_log[t0 + NW + SETTLE]), 32'd1);
    check("t1_busy_done", 32'(busy_log[t0 + NW + SETTLE + 1]), 32'd0);

    // 2: FIFO full for 3 cycles while entry 2 is presented
    clear_logs();
    t0 = cyc;
    do_req(18'h00101, 18'h01E1E, 18'h00303, 32'h8000_0000);
    idle(2);
    pll_busy = 1'b1;
    idle(3);
    pll_busy = 1'b0;
    wait_done(1, 80);
    idle(2);
    for (int i = 3; i <= 5; i++) begin
      check($sformatf("t2_stall_addr%0d", i), 32'(addr_log[t0 + i]), 32'd4);
      check($sformatf("t2_stall_wr%0d", i), 32'(write_log[t0 + i]), 32'd0);
    end
    check("t2_nwrites", 32'(wr_cyc.size()), 32'(NW));
    check_burst("t2", 0, 18'h00101, 18'h01E1E, 18'h00303, 32'h8000_0000);
    check("t2_m_wcyc", 32'(wcyc(2) - t0), 32'd6);
    check("t2_done_cyc", 32'(dcyc(0) - t0), 32'(NW + 3 + SETTLE + 1));

    // 3: two reqs while busy, only the newest is applied afterwards
    clear_logs();
    t0 = cyc;
    do_req(18'h00101, 18'h01E1E, 18'h00303, 32'h1111_0000);
    idle(2);
    do_req(18'h00101, 18'h00A0A, 18'h00303, 32'h2222_0000);
    idle(6);
    do_req(18'h00202, 18'h00B0B, 18'h00404, 32'h3333_0000);
    wait_done(2, 150);
    idle(3);
    check("t3_nwrites", 32'(wr_cyc.size()), 32'(2 * NW));
    check("t3_ndone", 32'(done_cyc.size()), 32'd2);
    check_burst("t3a", 0, 18'h00101, 18'h01E1E, 18'h00303, 32'h1111_0000);
    check_burst("t3b", NW, 18'h00202, 18'h00B0B, 18'h00404, 32'h3333_0000);
    check("t3_b2_start", 32'(wcyc(NW) - t0), 32'(NW + SETTLE + 3));
    check("t3_done2_cyc", 32'(dcyc(1) - t0), 32'(2 * NW + 2 * SETTLE + 3));

    // 4: reset one cycle after the addr-3 write, with a req pending
    clear_logs();
    t0 = cyc;
    do_req(18'h00101, 18'h01E1E, 18'h00303, 32'h0);
    do_req(18'h00111, 18'h01111, 18'h00111, 32'h0);
    run_cycle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    idle(8);
    check("t4_addr3_written", 32'(wr_addr.size() > 1 ? wr_addr[1] : 6'bx), 32'd3);
    check("t4_busy_after", 32'(busy_log[t0 + 4]), 32'd0);
    check("t4_done_after", 32'(done_log[t0 + 4]), 32'd0);
    late = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] >= t0 + 4) late++;
    check("t4_no_writes_after", 32'(late), 32'd0);
    clear_logs();
    t0 = cyc;
    do_req(18'h00101, 18'h01E1E, 18'h00303, 32'h0);
    run_cycle();
    check("t4_restart_n", 32'(wr_cyc.size()), 32'd1);
    check("t4_restart_addr", 32'(wr_addr.size() > 0 ? wr_addr[0] : 6'bx), 32'd0);
    check("t4_restart_cyc", 32'(wcyc(0) - t0), 32'd1);
    wait_done(1, 80);
    idle(2);
    check("t4_restart_done", 32'(done_cyc.size()), 32'd1);
    check("t4_restart_nwrites", 32'(wr_cyc.size()), 32'(NW));

    // 5: K / C_SEL handling for the current build
    clear_logs();
    do_req(18'h00101, 18'h01E1E, 18'h00303, 32'h8000_0000);
    wait_done(1, 80);
    idle(2);
`ifdef PLL_FRAC_EN
    check("t5_nwrites", 32'(wr_cyc.size()), 32'd6);
    check("t5_c_val", wr_val.size() > 3 ? wr_val[3] : 32'bx, 32'h0008_0303);
    v = wr_val.size() > 3 ? wr_val[3] : 32'bx;
    check("t5_c_sel", 32'(v[22:18]), 32'd2);
    check("t5_k_addr", 32'(wr_addr.size() > 4 ? wr_addr[4] : 6'bx), 32'd7);
    check("t5_k_val", wr_val.size() > 4 ? wr_val[4] : 32'bx, 32'h8000_0000);
    check("t5_start_addr", 32'(wr_addr.size() > 5 ? wr_addr[5] : 6'bx), 32'd2);
    check("t5_start_val", wr_val.size() > 5 ? wr_val[5] : 32'bx, 32'h1);
`else
    check("t5_nwrites", 32'(wr_cyc.size()), 32'd5);
    v = wr_val.size() > 3 ? wr_val[3] : 32'bx;
    check("t5_c_val", v, 32'h0000_0303);
    check("t5_start_addr", 32'(wr_addr.size() > 4 ? wr_addr[4] : 6'bx), 32'd2);
    check("t5_start_val", wr_val.size() > 4 ? wr_val[4] : 32'bx, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
